// File: rtl/sram_like_pkg.sv
// rtl/sram_like_pkg.sv - shared types and constants for the SRAM-like request/response protocol
package sram_like_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int DEPTH_MAX = 4;

  // One queued response: the write flag travels with the data so writes return zero
  typedef struct packed {
    logic        wr;
    logic [31:0] data;
  } rsp_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// rtl/sram_rsp_fifo.sv - in-order response FIFO holding responses that could not bypass
module sram_rsp_fifo
  import sram_like_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  rsp_t i_data,
  input  logic i_pop,
  output rsp_t o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  rsp_t          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Pointers wrap at DEPTH, which need not be a power of two
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd_ptr];

  // Storage needs no reset; only the pointers define what is valid
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping; push and pop together leave the count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (i_pop && !i_push) r_count <= r_count - 1'b1;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(i_push && o_full && !i_pop));
  a_no_underflow : assert property (@(posedge clk) disable iff (rst) !(i_pop && o_empty));

endmodule

// File: rtl/inst_sram_responder.sv
// rtl/inst_sram_responder.sv - SRAM-like responder; SRAM_RSP_RAND_DELAY_EN adds LFSR stalls and response holds
module inst_sram_responder
  import sram_like_pkg::*;
#(
  parameter int          DEPTH     = 2,
  parameter int          RAM_AW    = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int CW = $clog2(DEPTH + 1);

  logic          r_addr_ok;
  logic          r_pend;
  logic          r_pend_wr;
  logic [CW-1:0] r_cnt;

  logic          w_accept;
  logic          w_head_valid;
  logic          w_emit;
  logic          w_push;
  logic          w_pop;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_stall_next;
  logic          w_hold_zero;
  logic [CW-1:0] w_cnt_next;
  rsp_t          w_push_data;
  rsp_t          w_head;
  logic          w_unused_bits;

  assign w_accept  = req && r_addr_ok;
  assign addr_ok   = r_addr_ok;
  assign ram_en    = w_accept;
  assign ram_we    = (w_accept && wr) ? wstrb : 4'b0000;
  assign ram_addr  = addr[RAM_AW+1:2];
  assign ram_wdata = wdata;

  // The request accepted last cycle has its RAM data now; it bypasses only when nothing is queued ahead
  assign w_push_data.wr   = r_pend_wr;
  assign w_push_data.data = r_pend_wr ? 32'h0 : ram_rdata;
  assign w_head_valid     = r_pend || !w_fifo_empty;
  assign w_emit           = w_head_valid && w_hold_zero;
  assign w_pop            = w_emit && !w_fifo_empty;
  assign w_push           = r_pend && !(w_emit && w_fifo_empty);
  assign data_ok          = w_emit;

  // Response data mux: queued head first, else the bypassed fresh response
  always_comb begin
    rdata = 32'h0;
    if (w_emit) rdata = w_fifo_empty ? w_push_data.data : w_head.data;
  end

  // Outstanding count after this cycle's accept and response
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_accept && !w_emit)      w_cnt_next = r_cnt + 1'b1;
    else if (w_emit && !w_accept) w_cnt_next = r_cnt - 1'b1;
  end

`ifdef SRAM_RSP_RAND_DELAY_EN
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_next;
  logic [1:0]  r_hold;
  logic        r_hold_armed;

  assign w_lfsr_next  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_stall_next = w_lfsr_next[1] & w_lfsr_next[0];
  // A fresh head samples its extra hold from the LFSR; an armed head waits for the countdown
  assign w_hold_zero  = r_hold_armed ? (r_hold == 2'd0) : (r_lfsr[3:2] == 2'd0);

  // Free-running LFSR and per-head hold countdown
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr       <= LFSR_SEED;
      r_hold       <= 2'd0;
      r_hold_armed <= 1'b0;
    end else begin
      r_lfsr <= w_lfsr_next;
      if (w_emit) begin
        r_hold_armed <= 1'b0;
      end else if (w_head_valid) begin
        r_hold_armed <= 1'b1;
        r_hold       <= r_hold_armed ? (r_hold - 2'd1) : (r_lfsr[3:2] - 2'd1);
      end
    end
  end
`else
  assign w_stall_next = 1'b0;
  assign w_hold_zero  = 1'b1;
`endif

  // addr_ok is registered from the next count, so a response never frees a slot in its own cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr_ok <= 1'b0;
      r_pend    <= 1'b0;
      r_pend_wr <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_addr_ok <= (w_cnt_next < CW'(DEPTH)) && !w_stall_next;
      r_pend    <= w_accept;
      r_pend_wr <= wr;
      r_cnt     <= w_cnt_next;
    end
  end

  sram_rsp_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (reset),
    .i_push (w_push),
    .i_data (w_push_data),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_fifo_full),
    .o_empty(w_fifo_empty)
  );

  // size and the byte-offset/upper address bits are informational only
  assign w_unused_bits = ^{size, addr[1:0], addr[31:RAM_AW+2], w_head.wr, w_fifo_full, LFSR_SEED};

endmodule

// File: doc/inst_sram_responder.md
# inst_sram_responder

Responder end of the SRAM-like request/response protocol (req/addr_ok/data_ok) used by the fetch and memory stages. Accepts address requests, drives a single-port synchronous RAM with 1-cycle read latency, and returns responses strictly in request order through a small response FIFO. It serves as the instruction- and data-side memory model in the SoC-lite testbench, and as the base for the later AXI bridge.

## Interface
- DEPTH, 2: maximum outstanding accepted-but-unanswered requests (1..4).
- RAM_AW, 16: RAM word-address width; RAM holds 2^RAM_AW 32-bit words.
- LFSR_SEED, 16'hACE1: seed of the stall LFSR; used only with SRAM_RSP_RAND_DELAY_EN.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req  in  1  request valid from the initiator.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 = byte, 1 = half, 2 = word; informational, not decoded.
- wstrb  in  4  byte enables for writes.
- addr  in  32  byte address; bits [1:0] ignored.
- wdata  in  32  write data.
- addr_ok  out  1  request accepted this cycle when req && addr_ok.
- data_ok  out  1  one response returned this cycle; always consumed.
- rdata  out  32  read data valid with data_ok; 0 for write responses.
- ram_en  out  1  RAM access strobe.
- ram_we  out  4  RAM byte write enables.
- ram_addr  out  RAM_AW  RAM word address = addr[RAM_AW+1:2].
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en.

## Operation
- Accept = req && addr_ok. On accept: ram_en=1, ram_we = wr ? wstrb : 4'b0, ram_addr/ram_wdata from request; a pending slot {wr} is recorded.
- Cycle after accept: response data = wr ? 0 : ram_rdata. If FIFO empty and no delay active, it is returned directly (bypass); otherwise pushed into the response FIFO.
- data_ok pops FIFO head (or uses bypass); exactly one response per accepted request, in order.
- Outstanding counter cnt: +1 on accept, −1 on data_ok; both in one cycle → unchanged. Range 0..DEPTH.
- addr_ok = (cnt < DEPTH) && !stall. A data_ok in the same cycle does not free a slot for that cycle (no combinational path data_ok→addr_ok).
- No back-pressure on data_ok; initiator must always accept responses, including for requests it has logically cancelled.
- Writes complete into RAM at the accept edge; a read accepted the following cycle to the same word returns the new data.
- FIFO depth = DEPTH; overflow impossible by the cnt rule; a push with FIFO full is an assertion failure.

## Timing
- Reset values: addr_ok 0, data_ok 0, rdata 0, ram_en 0, ram_we 0, cnt 0, FIFO empty, LFSR = LFSR_SEED.
- ram_en/ram_we/ram_addr/ram_wdata combinational from req, addr_ok, request fields.
- Minimum latency: accept at cycle T → data_ok at T+1 (bypass).
- Back-to-back: one accept per cycle sustained at DEPTH≥2 with no delay; throughput 1 response/cycle.
- Reset asserted mid-operation: outstanding requests dropped, no data_ok issued for them; RAM contents untouched.

## Configuration
- SRAM_RSP_RAND_DELAY_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle; stall = lfsr[1]&lfsr[0] masks addr_ok; each response head is held lfsr[3:2] extra cycles (0..3) before data_ok; bypass disabled while a hold is counting.
- Not defined: stall=0, hold=0; fixed 1-cycle latency, addr_ok purely cnt-based.

## Structure
- Package sram_like_pkg: SIZE_BYTE/SIZE_HALF/SIZE_WORD constants, DEPTH_MAX=4, response struct {wr, data[31:0]}.
- One sub-module: sram_rsp_fifo (parameterised DEPTH, push/pop/full/empty, pointer wrap modulo DEPTH, simultaneous push+pop with full legal).
- Delay LFSR and hold counter stay in the top module under the macro.

## Test plan
- Single read: RAM[0x10>>2]=0x12345678, req addr 0x10 at T → addr_ok T, data_ok T+1, rdata 0x12345678.
- Write then read: write 0xDEADBEEF wstrb 4'b0011 to 0x20 (word was 0), read 0x20 next cycle → data_ok twice, second rdata 0x0000BEEF.
- Saturation: req held high for 8 reads, DEPTH=2 → cnt never exceeds 2, 8 data_ok in order, addresses matched.
- Outstanding full: DEPTH=1, req every cycle → addr_ok alternates 1,0,1,0; data_ok one cycle after each accept.
- Reset mid-flight: assert reset the cycle after accept → data_ok stays 0, cnt=0, next request after release returns normally.
- Random delay (macro on): 1000 random reads/writes against scoreboard → all responses in order, count equal to accepts, no FIFO overflow assertion.
